// File: rtl/hybrid_cache_line_ctrl.sv
// Hybrid cache line write-port controller: sequences line refills and arbitrates CPU stores.
// Optional feature macro: HYBRID_CACHE_CRITICAL_WORD_FIRST_EN (refill starts at the missed word).
module hybrid_cache_line_ctrl #(
  parameter int unsigned ADDRBITS    = 32,
  parameter int unsigned DATABITS    = 32,
  parameter int unsigned LSBBITS     = 7,
  parameter int unsigned WORDLENBITS = 2,
  parameter int unsigned WORDIDXBITS = LSBBITS - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fill_req,
  input  logic [ADDRBITS-1:0]    fill_addr,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic                   mem_rd,
  output logic [ADDRBITS-1:0]    mem_addr,
  input  logic                   mem_valid,
  input  logic [DATABITS-1:0]    mem_data,
  input  logic                   cpu_we,
  input  logic [LSBBITS-1:0]     cpu_addr,
  input  logic [WORDLENBITS-1:0] cpu_wordlen,
  input  logic [DATABITS-1:0]    cpu_wdata,
  output logic                   cpu_stall,
  output logic                   cpu_misalign,
  output logic [LSBBITS-1:0]     line_mem_wraddr,
  output logic                   line_mem_we,
  output logic [DATABITS-1:0]    line_mem_in,
  output logic [WORDLENBITS-1:0] line_mem_in_wordlen
);

  localparam int unsigned BASEBITS = ADDRBITS - LSBBITS;
  localparam logic [WORDIDXBITS-1:0] LAST_BEAT = {WORDIDXBITS{1'b1}};
  localparam logic [WORDLENBITS-1:0] WL_BYTE = WORDLENBITS'(0);
  localparam logic [WORDLENBITS-1:0] WL_HALF = WORDLENBITS'(1);
  localparam logic [WORDLENBITS-1:0] WL_WORD = WORDLENBITS'(2);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [BASEBITS-1:0]    line_base;
  logic [WORDIDXBITS-1:0] word_idx;
  logic [WORDIDXBITS-1:0] beat_cnt;
  logic [WORDIDXBITS-1:0] next_idx;
  logic [WORDIDXBITS-1:0] start_idx;
  logic                   store_legal;
  logic                   last_beat;

`ifdef HYBRID_CACHE_CRITICAL_WORD_FIRST_EN
  logic [1:0] unused_byte_lsb;
  assign unused_byte_lsb = fill_addr[1:0];
  assign start_idx       = fill_addr[LSBBITS-1:2];
`else
  logic [LSBBITS-1:0] unused_line_offset;
  assign unused_line_offset = fill_addr[LSBBITS-1:0];
  assign start_idx          = '0;
`endif

  assign next_idx  = word_idx + WORDIDXBITS'(1);
  assign last_beat = (state == FILL) && mem_valid && (beat_cnt == LAST_BEAT);

  // Legal store size/offset pairs; anything else is dropped and flagged
  always_comb begin
    store_legal = 1'b0;
    case (cpu_wordlen)
      WL_BYTE: store_legal = 1'b1;
      WL_HALF: store_legal = ~cpu_addr[0];
      WL_WORD: store_legal = (cpu_addr[1:0] == 2'b00);
      default: store_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fill_req) state_next = REQ;
      REQ:     state_next = FILL;
      FILL:    if (last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fill_busy = 1'b0;
    fill_done = 1'b0;
    mem_rd    = 1'b0;
    case (state)
      REQ:     fill_busy = 1'b1;
      FILL: begin
        fill_busy = 1'b1;
        mem_rd    = 1'b1;
      end
      DONE:    fill_done = 1'b1;
      default: ;
    endcase
    cpu_stall = (state != IDLE) && cpu_we;
  end

  // Write port: CPU stores in IDLE, refill beats in FILL
  always_ff @(posedge clk) begin
    if (reset) begin
      line_base           <= '0;
      word_idx            <= '0;
      beat_cnt            <= '0;
      mem_addr            <= '0;
      line_mem_we         <= 1'b0;
      line_mem_wraddr     <= '0;
      line_mem_in         <= '0;
      line_mem_in_wordlen <= '0;
      cpu_misalign        <= 1'b0;
    end else begin
      line_mem_we  <= 1'b0;
      cpu_misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_we) begin
            if (store_legal) begin
              line_mem_we         <= 1'b1;
              line_mem_wraddr     <= cpu_addr;
              line_mem_in         <= cpu_wdata;
              line_mem_in_wordlen <= cpu_wordlen;
            end else begin
              cpu_misalign <= 1'b1;
            end
          end
          if (fill_req) begin
            line_base <= fill_addr[ADDRBITS-1:LSBBITS];
            word_idx  <= start_idx;
          end
        end
        REQ: begin
          beat_cnt <= '0;
          mem_addr <= {line_base, word_idx, 2'b00};
        end
        FILL: begin
          if (mem_valid) begin
            line_mem_we         <= 1'b1;
            line_mem_wraddr     <= {word_idx, 2'b00};
            line_mem_in         <= mem_data;
            line_mem_in_wordlen <= WL_WORD;
            word_idx            <= next_idx;
            beat_cnt            <= beat_cnt + WORDIDXBITS'(1);
            mem_addr            <= {line_base, next_idx, 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hybrid_cache_line_ctrl.sv
// Self-checking bench for hybrid_cache_line_ctrl: cycle model of the refill/store rules plus directed literals.
// Honours HYBRID_CACHE_CRITICAL_WORD_FIRST_EN when the design is built with it.
module tb_hybrid_cache_line_ctrl;

  logic        clk;
  logic        reset;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic        fill_busy;
  logic        fill_done;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        cpu_we;
  logic [6:0]  cpu_addr;
  logic [1:0]  cpu_wordlen;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_misalign;
  logic [6:0]  line_mem_wraddr;
  logic        line_mem_we;
  logic [31:0] line_mem_in;
  logic [1:0]  line_mem_in_wordlen;

  int checks = 0;
  int errors = 0;

`ifdef HYBRID_CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
  localparam logic [31:0] A_MA = 32'h0000_1234;
  localparam logic [6:0]  A_FW = 7'h34, A_LW = 7'h30;
  localparam logic [31:0] B_MA = 32'h0000_5678;
  localparam logic [6:0]  B_FW = 7'h78, B_LW = 7'h74;
  localparam logic [31:0] C_MA = 32'h0000_1274;
  localparam logic [6:0]  C_FW = 7'h74, C_LW = 7'h70;
`else
  localparam bit CWF = 1'b0;
  localparam logic [31:0] A_MA = 32'h0000_1200;
  localparam logic [6:0]  A_FW = 7'h00, A_LW = 7'h7C;
  localparam logic [31:0] B_MA = 32'h0000_5600;
  localparam logic [6:0]  B_FW = 7'h00, B_LW = 7'h7C;
  localparam logic [31:0] C_MA = 32'h0000_1200;
  localparam logic [6:0]  C_FW = 7'h00, C_LW = 7'h7C;
`endif

  hybrid_cache_line_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .fill_req            (fill_req),
    .fill_addr           (fill_addr),
    .fill_busy           (fill_busy),
    .fill_done           (fill_done),
    .mem_rd              (mem_rd),
    .mem_addr            (mem_addr),
    .mem_valid           (mem_valid),
    .mem_data            (mem_data),
    .cpu_we              (cpu_we),
    .cpu_addr            (cpu_addr),
    .cpu_wordlen         (cpu_wordlen),
    .cpu_wdata           (cpu_wdata),
    .cpu_stall           (cpu_stall),
    .cpu_misalign        (cpu_misalign),
    .line_mem_wraddr     (line_mem_wraddr),
    .line_mem_we         (line_mem_we),
    .line_mem_in         (line_mem_in),
    .line_mem_in_wordlen (line_mem_in_wordlen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 request, 2 streaming beats, 3 done pulse
  int          phase = 0;
  int          beats = 0;
  int          start = 0;
  logic [31:0] base_addr = '0;
  bit          started = 1'b0;
  logic        e_we = 1'b0;
  logic        e_mis = 1'b0;
  logic [6:0]  e_wraddr = '0;
  logic [31:0] e_in = '0;
  logic [1:0]  e_wl = '0;
  logic [31:0] e_mem_addr = '0;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      phase = 0; beats = 0; e_we = 1'b0; e_mis = 1'b0;
      e_wraddr = '0; e_in = '0; e_wl = '0; e_mem_addr = '0;
    end else begin
      e_we  = 1'b0;
      e_mis = 1'b0;
      case (phase)
        0: begin
          if (cpu_we) begin
            if ((cpu_wordlen == 2'd0) ||
                (cpu_wordlen == 2'd1 && (cpu_addr % 2) == 0) ||
                (cpu_wordlen == 2'd2 && (cpu_addr % 4) == 0)) begin
              e_we = 1'b1; e_wraddr = cpu_addr; e_in = cpu_wdata; e_wl = cpu_wordlen;
            end else begin
              e_mis = 1'b1;
            end
          end
          if (fill_req) begin
            base_addr = fill_addr & ~32'd127;
            start     = CWF ? int'((fill_addr >> 2) % 32) : 0;
            phase     = 1;
          end
        end
        1: begin
          beats = 0;
          e_mem_addr = base_addr + 32'(start * 4);
          phase = 2;
        end
        2: begin
          if (mem_valid) begin
            e_we = 1'b1; e_wl = 2'd2; e_in = mem_data;
            e_wraddr = 7'(((start + beats) % 32) * 4);
            beats++;
            e_mem_addr = base_addr + 32'(((start + beats) % 32) * 4);
            if (beats == 32) phase = 3;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("fill_busy", fill_busy, (phase == 1 || phase == 2));
      chk("fill_done", fill_done, (phase == 3));
      chk("mem_rd", mem_rd, (phase == 2));
      chk("cpu_stall", cpu_stall, (phase != 0) && cpu_we);
      chk("line_mem_we", line_mem_we, e_we);
      chk("cpu_misalign", cpu_misalign, e_mis);
      if (e_we) begin
        chk("line_mem_wraddr", line_mem_wraddr, e_wraddr);
        chk("line_mem_in", line_mem_in, e_in);
        chk("line_mem_in_wordlen", line_mem_in_wordlen, e_wl);
      end
      if (phase == 2) chk("mem_addr", mem_addr, e_mem_addr);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [31:0] a, input int gap, input logic [31:0] first_ma,
                         input logic [6:0] first_wr, input logic [6:0] last_wr);
    fill_addr = a; fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    chk("req_busy", fill_busy, 1);
    chk("req_no_rd", mem_rd, 0);
    step(1);
    chk("fill_rd", mem_rd, 1);
    chk("first_mem_addr", mem_addr, first_ma);
    for (int i = 0; i < 32; i++) begin
      mem_valid = 1'b0;
      if (gap > 0) step(gap);
      mem_valid = 1'b1;
      mem_data  = 32'hA500_0000 + 32'(i);
      step(1);
      if (i == 0) chk("first_wraddr", line_mem_wraddr, first_wr);
    end
    mem_valid = 1'b0;
    chk("done_pulse", fill_done, 1);
    chk("last_wraddr", line_mem_wraddr, last_wr);
    chk("last_data", line_mem_in, 32'hA500_001F);
    step(1);
    chk("done_one_cycle", fill_done, 0);
    chk("idle_not_busy", fill_busy, 0);
  endtask

  task automatic store(input logic [6:0] a, input logic [1:0] wl, input logic [31:0] d,
                       input logic exp_we, input logic exp_mis);
    cpu_we = 1'b1; cpu_addr = a; cpu_wordlen = wl; cpu_wdata = d;
    step(1);
    cpu_we = 1'b0;
    chk("store_we", line_mem_we, exp_we);
    chk("store_misalign", cpu_misalign, exp_mis);
    chk("store_no_stall", cpu_stall, 0);
    if (exp_we) chk("store_wraddr", line_mem_wraddr, a);
  endtask

  initial begin
    reset = 1'b1; fill_req = 1'b0; fill_addr = '0; mem_valid = 1'b0; mem_data = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_wordlen = '0; cpu_wdata = '0;
    step(2);
    chk("rst_busy", fill_busy, 0);
    chk("rst_done", fill_done, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_we", line_mem_we, 0);
    chk("rst_mis", cpu_misalign, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wraddr", line_mem_wraddr, 0);
    chk("rst_in", line_mem_in, 0);
    chk("rst_wl", line_mem_in_wordlen, 0);
    reset = 1'b0;

    // stray mem_valid in IDLE must not write
    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
    step(2);
    chk("idle_valid_ignored", line_mem_we, 0);
    mem_valid = 1'b0;

    do_fill(32'h0000_1234, 0, A_MA, A_FW, A_LW);
    do_fill(32'h0000_5678, 2, B_MA, B_FW, B_LW);

    store(7'h05, 2'd0, 32'h0000_0011, 1'b1, 1'b0);
    store(7'h06, 2'd1, 32'h0000_2222, 1'b1, 1'b0);
    store(7'h05, 2'd1, 32'h0000_3333, 1'b0, 1'b1);
    store(7'h02, 2'd2, 32'h4444_4444, 1'b0, 1'b1);
    store(7'h00, 2'd3, 32'h5555_5555, 1'b0, 1'b1);
    store(7'h08, 2'd2, 32'h6666_6666, 1'b1, 1'b0);

    // store and fill together, store held through the fill
    cpu_we = 1'b1; cpu_addr = 7'h10; cpu_wordlen = 2'd2; cpu_wdata = 32'hCAFE_F00D;
    fill_addr = 32'h0000_3000; fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    chk("simul_store_we", line_mem_we, 1);
    chk("simul_store_addr", line_mem_wraddr, 7'h10);
    chk("simul_stall_req", cpu_stall, 1);
    step(1);
    for (int i = 0; i < 32; i++) begin
      mem_valid = 1'b1; mem_data = 32'hB000_0000 + 32'(i);
      step(1);
    end
    mem_valid = 1'b0;
    chk("held_stall_done", cpu_stall, 1);
    step(1);
    chk("held_no_stall_idle", cpu_stall, 0);
    chk("held_not_yet", line_mem_we, 0);
    step(1);
    cpu_we = 1'b0;
    chk("held_store_we", line_mem_we, 1);
    chk("held_store_data", line_mem_in, 32'hCAFE_F00D);

    // reset on beat 10 aborts the fill
    fill_addr = 32'h0000_4000; fill_req = 1'b1;
    step(1);
    fill_req = 1'b0;
    step(1);
    for (int i = 0; i < 10; i++) begin
      mem_valid = 1'b1; mem_data = 32'hC000_0000 + 32'(i);
      step(1);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0; mem_valid = 1'b0;
    chk("abort_rd", mem_rd, 0);
    chk("abort_busy", fill_busy, 0);
    chk("abort_we", line_mem_we, 0);
    chk("abort_no_done", fill_done, 0);
    step(3);
    chk("abort_still_no_done", fill_done, 0);

    do_fill(32'h0000_1274, 0, C_MA, C_FW, C_LW);

    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hybrid_cache_line_ctrl.md
Name: hybrid_cache_line_ctrl

Overview:
Write-port controller for the hybrid cache line memory block. Sequences a full line refill from external memory into the line memory, one 32-bit word per accepted beat. Arbitrates that refill against CPU byte, half-word and word store writes. Sits between the cache tag/miss logic, the external memory interface and the line memory's write port; the line memory's read port is not touched.

Parameters:
ADDRBITS, 32, external byte address width
DATABITS, 32, data width; fixed at 32
LSBBITS, 7, byte-offset bits within a line (line = 2**LSBBITS bytes)
WORDLENBITS, 2, width of the word-length code
WORDIDXBITS, LSBBITS-2, word index width within a line

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
fill_req  input  1  start a line refill; sampled only in IDLE
fill_addr  input  ADDRBITS  miss byte address; sampled with fill_req
fill_busy  output  1  high in REQ/FILL
fill_done  output  1  one-cycle pulse when the last word has been written
mem_rd  output  1  read request to external memory; held high during FILL
mem_addr  output  ADDRBITS  word-aligned address of the current beat
mem_valid  input  1  external read data valid (one beat)
mem_data  input  DATABITS  external read data
cpu_we  input  1  CPU store request
cpu_addr  input  LSBBITS  CPU store byte offset within the line
cpu_wordlen  input  WORDLENBITS  0 = byte, 1 = half-word, 2 = word
cpu_wdata  input  DATABITS  CPU store data
cpu_stall  output  1  CPU store not accepted this cycle
cpu_misalign  output  1  one-cycle pulse for an illegal wordlen/offset pair
line_mem_wraddr  output  LSBBITS  to line memory write address
line_mem_we  output  1  to line memory write enable
line_mem_in  output  DATABITS  to line memory write data
line_mem_in_wordlen  output  WORDLENBITS  to line memory write length

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; fill_busy, fill_done, mem_rd, line_mem_we and cpu_misalign all 0; mem_addr, line_mem_wraddr, line_mem_in and line_mem_in_wordlen all 0; beat counter 0.
- All line_mem_* outputs are registered. A write reaches the line memory one cycle after it is accepted.
- States:
  - IDLE: fill_req=1 latches fill_addr and goes to REQ.
  - REQ: one cycle. Loads the beat counter, drives mem_addr, goes to FILL.
  - FILL: mem_rd=1.
    - On mem_valid: register line_mem_we=1, line_mem_in_wordlen=2, line_mem_wraddr={word index,2'b00}, line_mem_in=mem_data. Then advance the word index (modulo 2**WORDIDXBITS) and the beat counter, and update mem_addr={line base, next index, 2'b00}.
    - When mem_valid arrives on beat 2**WORDIDXBITS-1: go to DONE and drop mem_rd on the next edge.
    - mem_valid=0 cycles hold all state.
  - DONE: fill_done=1 for one cycle, then IDLE.
- Line base is fill_addr[ADDRBITS-1:LSBBITS]. A full fill is exactly 2**WORDIDXBITS beats (32 at defaults).
- CPU arbitration:
  - cpu_stall is combinational: high when state is REQ, FILL or DONE and cpu_we=1, otherwise 0.
  - In IDLE, cpu_we is accepted: line_mem_* take cpu_addr, cpu_wdata and cpu_wordlen next cycle. The CPU is responsible for pre-rotating nothing; the line memory handles lane rotation.
  - fill_req and cpu_we together in IDLE: the store is accepted and the fill starts (REQ next cycle). No stall.
- Alignment check on an accepted store. Legal pairs:
  - byte: any offset;
  - half-word: offset[1:0] = 0 or 2;
  - word: offset[1:0] = 0.
  - Any other pair, including wordlen=3: cpu_misalign=1 next cycle, line_mem_we=0, store dropped, no stall.
- fill_req outside IDLE: ignored; it is not queued.
- Reset during FILL: aborts the fill. mem_rd=0 and line_mem_we=0 after the edge; no fill_done.
- mem_valid outside FILL: ignored.

Optional Feature:
HYBRID_CACHE_CRITICAL_WORD_FIRST_EN
- Defined: the fill starts at word index fill_addr[LSBBITS-1:2] and wraps modulo the line size. fill_done comes after the word just before the start index has been written.
- Undefined: the fill always starts at index 0 and ends at index 2**WORDIDXBITS-1; fill_addr[LSBBITS-1:0] is ignored.

Test Plan:
- Fill, mem_valid every cycle, fill_addr=0x00001234 -> mem_addr 0x00001200, 0x00001204 … 0x0000127C; 32 line writes with wraddr 0x00 … 0x7C, wordlen 2; fill_done exactly one cycle after the 32nd beat; fill_busy high for REQ+FILL.
- Fill with mem_valid every third cycle -> same 32 writes; no write in gap cycles; mem_rd held continuously.
- IDLE stores -> cpu_addr=0x05 wordlen0 gives we=1, wraddr 0x05 one cycle later. Addr 0x06 wordlen1 is accepted. Addr 0x05 wordlen1, addr 0x02 wordlen2 and wordlen3 each give cpu_misalign=1 and we=0.
- cpu_we held during fill -> cpu_stall=1 in every REQ/FILL/DONE cycle; the store lands the cycle after IDLE resumes. Simultaneous fill_req+cpu_we in IDLE -> store written, fill begins.
- Reset asserted on beat 10 -> mem_rd=0 and fill_busy=0 next cycle, no fill_done. A new fill then completes normally.
- With HYBRID_CACHE_CRITICAL_WORD_FIRST_EN, fill_addr=0x1274 -> wraddr order 0x74, 0x78, 0x7C, 0x00 … 0x70; fill_done after 0x70.
